tlc_input_cond: RTL and testbench

Input-conditioning stage that sits directly upstream of the traffic-light top level, between the board switches/buttons and the controller/timer.
- Synchronises every raw switch and button bit to clk, debounces it, and produces clean levels plus one-cycle press pulses.
- Derives the controller inputs car_ns, car_ew and a sticky ped_req, which holds until the controller acknowledges it.

---
 rtl/tlc_pkg.sv | 21 ++
 rtl/tlc_input_cond_debounce_bit.sv | 85 ++++++++
 rtl/tlc_input_cond.sv | 83 ++++++++
 tb/tb_tlc_input_cond.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types and switch/button bit assignments for the traffic-light
// input-conditioning stage.
package tlc_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        RISE_WAIT   = 2'b01,
        HIGH_STABLE = 2'b10,
        FALL_WAIT   = 2'b11
    } db_state_t;

    localparam int SW_NS_HI   = 7;
    localparam int SW_NS_LO   = 5;
    localparam int SW_PED_HI  = 4;
    localparam int SW_PED_LO  = 3;
    localparam int SW_EW_HI   = 2;
    localparam int SW_EW_LO   = 0;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_CENTER = 4;

endpackage

// File: rtl/tlc_input_cond_debounce_bit.sv
// One input bit: multi-flop synchroniser followed by a four-state debounce
// FSM; db is the accepted level and rise pulses for one cycle when db rises.
module debounce_bit
    import tlc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_q, rise_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        case (state_q)
            LOW_STABLE: if (s) begin
                state_d = RISE_WAIT;
                cnt_d   = '0;
            end
            RISE_WAIT: begin
                if (!s) begin
                    state_d = LOW_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH_STABLE;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH_STABLE: if (!s) begin
                state_d = FALL_WAIT;
                cnt_d   = '0;
            end
            FALL_WAIT: begin
                if (s) begin
                    state_d = HIGH_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW_STABLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = LOW_STABLE;
        endcase
    end

    // Decoded straight from the state flops: db changes only on a clock edge.
    assign db   = (state_q == HIGH_STABLE) || (state_q == FALL_WAIT);
    assign rise = rise_q;

endmodule

// File: rtl/tlc_input_cond.sv
// Board switch/button conditioning: per-bit debounce plus derivation of the
// controller inputs car_ns, car_ew, the sticky ped_req and timer controls.
module tlc_input_cond
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2,
    parameter int N_SW            = 8,
    parameter int N_BTN           = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             ped_ack,
    output logic [N_SW-1:0]  sw_db,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_press,
    output logic             car_ns,
    output logic             car_ew,
    output logic             ped_req,
    output logic             timer_rst,
    output logic             timer_load
);

    logic [N_SW-1:0] sw_rise_unused;
    logic            ped_or;
    logic            ped_or_q;
    logic            ped_req_q, ped_req_d;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (sw_raw[i]),
            .db     (sw_db[i]),
            .rise   (sw_rise_unused[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (btn_raw[i]),
            .db     (btn_db[i]),
            .rise   (btn_press[i])
        );
    end

    assign car_ns     = |sw_db[SW_NS_HI:SW_NS_LO];
    assign car_ew     = |sw_db[SW_EW_HI:SW_EW_LO];
    assign timer_rst  = btn_db[BTN_DOWN];
    assign timer_load = btn_press[BTN_CENTER];
    assign ped_or     = |sw_db[SW_PED_HI:SW_PED_LO];

    // Edge-triggered set so a held switch cannot re-arm after an ack;
    // set is applied last so it wins over a coincident ack.
    always_comb begin
        ped_req_d = ped_req_q;
        if (ped_ack) ped_req_d = 1'b0;
        if (ped_or && !ped_or_q) ped_req_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_or_q  <= 1'b0;
            ped_req_q <= 1'b0;
        end else begin
            ped_or_q  <= ped_or;
            ped_req_q <= ped_req_d;
        end
    end

    assign ped_req = ped_req_q;

endmodule

// File: tb/tb_tlc_input_cond.sv
// Directed bench for tlc_input_cond with DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2:
// inputs change just after a falling edge, outputs are sampled on falling edges.
module tb_tlc_input_cond;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sw_raw;
    logic [4:0] btn_raw;
    logic       ped_ack;
    logic [7:0] sw_db;
    logic [4:0] btn_db;
    logic [4:0] btn_press;
    logic       car_ns, car_ew, ped_req, timer_rst, timer_load;

    int n_checks = 0;
    int n_fail   = 0;

    tlc_input_cond #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .N_SW           (8),
        .N_BTN          (5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw_raw    (sw_raw),
        .btn_raw   (btn_raw),
        .ped_ack   (ped_ack),
        .sw_db     (sw_db),
        .btn_db    (btn_db),
        .btn_press (btn_press),
        .car_ns    (car_ns),
        .car_ew    (car_ew),
        .ped_req   (ped_req),
        .timer_rst (timer_rst),
        .timer_load(timer_load)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse ped_ack so exactly one rising edge samples it.
    task automatic ack_pulse();
        ped_ack = 1'b1;
        tick(1);
        ped_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        sw_raw  = '0;
        btn_raw = '0;
        ped_ack = 1'b0;
        tick(2);
        check("rst_sw_db",     32'(sw_db),     32'h0);
        check("rst_btn_db",    32'(btn_db),    32'h0);
        check("rst_btn_press", 32'(btn_press), 32'h0);
        check("rst_ped_req",   32'(ped_req),   32'h0);
        reset_n = 1'b1;
        tick(2);

        // Clean press and release on btn_raw[4]: db changes 6 edges after first sample.
        btn_raw[4] = 1'b1;
        tick(6);
        check("press_db_early",  32'(btn_db[4]),  32'h0);
        check("press_load_early", 32'(timer_load), 32'h0);
        tick(1);
        check("press_db",     32'(btn_db[4]),    32'h1);
        check("press_pulse",  32'(btn_press[4]), 32'h1);
        check("press_load",   32'(timer_load),   32'h1);
        tick(1);
        check("press_pulse_end", 32'(btn_press[4]), 32'h0);
        check("press_load_end",  32'(timer_load),   32'h0);
        check("press_db_hold",   32'(btn_db[4]),    32'h1);
        tick(2);
        btn_raw[4] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("release_db_hold",  32'(btn_db[4]),    32'h1);
            check("release_no_pulse", 32'(btn_press[4]), 32'h0);
        end
        tick(1);
        check("release_db",       32'(btn_db[4]),    32'h0);
        check("release_no_pulse", 32'(btn_press[4]), 32'h0);

        // Bounce on sw_raw[6]: count restarts at the final 0->1.
        sw_raw[6] = 1'b1;
        tick(1);
        sw_raw[6] = 1'b0;
        tick(1);
        sw_raw[6] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("bounce_db_low", 32'(sw_db[6]), 32'h0);
            check("bounce_ns_low", 32'(car_ns),   32'h0);
        end
        tick(1);
        check("bounce_db", 32'(sw_db[6]), 32'h1);
        check("bounce_ns", 32'(car_ns),   32'h1);

        // Three-cycle glitch on sw_raw[0] is rejected.
        sw_raw[0] = 1'b1;
        tick(3);
        sw_raw[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_db", 32'(sw_db[0]), 32'h0);
            check("glitch_ew", 32'(car_ew),   32'h0);
        end
        sw_raw[6] = 1'b0;
        tick(9);
        check("ns_cleared", 32'(car_ns), 32'h0);

        // Pedestrian request latch.
        sw_raw[3] = 1'b1;
        tick(9);
        check("ped_set", 32'(ped_req), 32'h1);
        ack_pulse();
        check("ped_clr", 32'(ped_req), 32'h0);
        tick(5);
        check("ped_no_rearm", 32'(ped_req), 32'h0);
        sw_raw[3] = 1'b0;
        tick(9);
        check("ped_off", 32'(ped_req), 32'h0);
        sw_raw[3] = 1'b1;
        tick(9);
        check("ped_rearm", 32'(ped_req), 32'h1);
        ack_pulse();
        check("ped_clr2", 32'(ped_req), 32'h0);
        sw_raw[3] = 1'b0;
        tick(9);
        sw_raw[3] = 1'b1;
        tick(7);
        check("ped_db_rise", 32'(sw_db[3]), 32'h1);
        ack_pulse();
        check("ped_set_wins", 32'(ped_req), 32'h1);
        tick(3);
        check("ped_set_stays", 32'(ped_req), 32'h1);
        sw_raw[3] = 1'b0;
        ack_pulse();
        tick(9);

        // Asynchronous reset mid-count on btn_raw[2], with other outputs high.
        sw_raw[5] = 1'b1;
        sw_raw[4] = 1'b1;
        tick(9);
        check("pre_rst_ns",  32'(car_ns),  32'h1);
        check("pre_rst_ped", 32'(ped_req), 32'h1);
        btn_raw[2] = 1'b1;
        tick(5);
        #2 reset_n = 1'b0;
        #1;
        check("async_sw_db",   32'(sw_db),     32'h0);
        check("async_btn_db",  32'(btn_db),    32'h0);
        check("async_ns",      32'(car_ns),    32'h0);
        check("async_ped",     32'(ped_req),   32'h0);
        check("async_tmr_rst", 32'(timer_rst), 32'h0);
        tick(3);
        reset_n = 1'b1;
        tick(6);
        check("post_rst_early", 32'(timer_rst), 32'h0);
        tick(1);
        check("post_rst_tmr", 32'(timer_rst), 32'h1);
        check("post_rst_ns",  32'(car_ns),    32'h1);
        sw_raw  = '0;
        btn_raw = '0;
        ack_pulse();
        tick(10);
        check("cleared_ns",  32'(car_ns),    32'h0);
        check("cleared_tmr", 32'(timer_rst), 32'h0);

        // Independent bits rising together assert together.
        sw_raw[7]  = 1'b1;
        btn_raw[2] = 1'b1;
        tick(6);
        check("indep_ns_early",  32'(car_ns),    32'h0);
        check("indep_tmr_early", 32'(timer_rst), 32'h0);
        tick(1);
        check("indep_ns",  32'(car_ns),    32'h1);
        check("indep_tmr", 32'(timer_rst), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
